// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done conversion bus between a binary source and the BCD converter.
// The master drives the operand and start; the slave returns status and the held result.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter; result lands WIDTH edges after start is accepted.
// start is only sampled while idle (no queueing); bcd holds the last result between completions.
module bin2bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  bin_q;
    logic [BW-1:0]     scr_q;
    logic [BW-1:0]     bcd_q;
    logic              busy_q;
    logic              done_q;

    logic [BW-1:0]     scr_fix;
    logic [BW-1:0]     scr_d;
    logic [WIDTH-1:0]  bin_d;

    // One bank of add-3 correctors, applied to every digit before the shift.
    always_comb begin
        scr_fix = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_fix[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        scr_d = {scr_fix[BW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        bin_q   <= bus.bin;
                        scr_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q <= scr_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CW'(1);
                    // Last shift: publish the post-shift scratch and free the block.
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= scr_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed plus randomized bench for bin2bcd_seq against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;
    localparam int WIDTH  = 10;
    localparam int DIGITS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: decimal digits by repeated division, packed units-first.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then wait (bounded) for done; optionally scramble bin/start while busy.
    task automatic run_conv(input int v, input bit perturb, output int lat, output int busy_cnt);
        bus.bin   = WIDTH'(v);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        while (!bus.done && lat < 4*WIDTH) begin
            if (bus.busy) busy_cnt++;
            if (perturb) begin
                bus.bin   = WIDTH'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int lat, bc, dones, first, second;
        logic [4*DIGITS-1:0] exp;

        bus.start = 1'b0;
        bus.bin   = '0;

        #2;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_bcd",  32'(bus.bcd),  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        run_conv(0, 1'b0, lat, bc);
        check("zero_lat", lat, WIDTH);
        check("zero_bcd", 32'(bus.bcd), 32'h0000);

        run_conv(1023, 1'b0, lat, bc);
        check("max_lat",       lat, WIDTH);
        check("max_busy_cyc",  bc, WIDTH);
        check("max_busy_done", 32'(bus.busy), 0);
        check("max_bcd",       32'(bus.bcd), 32'h1023);
        tick();
        check("max_done_drop", 32'(bus.done), 0);

        run_conv(599, 1'b0, lat, bc);
        check("c599", 32'(bus.bcd), 32'h0599);
        run_conv(999, 1'b0, lat, bc);
        check("c999", 32'(bus.bcd), 32'h0999);
        run_conv(500, 1'b0, lat, bc);
        check("c500", 32'(bus.bcd), 32'h0500);

        // Full sweep with random bin/start noise while busy.
        for (int v = 0; v < (1 << WIDTH); v++) begin
            run_conv(v, 1'b1, lat, bc);
            exp = ref_bcd(v);
            check($sformatf("sweep_lat_%0d", v), lat, WIDTH);
            check($sformatf("sweep_bcd_%0d", v), 32'(bus.bcd), 32'(exp));
        end
        tick();

        // Asynchronous reset between edges clears outputs immediately.
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_done", 32'(bus.done), 0);
        check("async_rst_bcd",  32'(bus.bcd),  0);
        tick();
        rst_n = 1'b1;
        tick();

        // Start during busy is dropped.
        bus.bin   = WIDTH'(37);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.bin   = WIDTH'(812);
        tick();
        bus.start = 1'b0;
        bus.bin   = WIDTH'($urandom);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("ign_dones", dones, 1);
        check("ign_bcd",   32'(bus.bcd), 32'h0037);

        // Back-to-back with start held high.
        bus.bin   = WIDTH'(256);
        bus.start = 1'b1;
        tick();
        first  = -1;
        second = -1;
        dones  = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.done) begin
                dones++;
                if (first < 0) begin
                    first = i;
                    check("b2b_bcd0", 32'(bus.bcd), 32'h0256);
                    bus.bin = WIDTH'(1000);
                end else if (second < 0) begin
                    second = i;
                    check("b2b_bcd1", 32'(bus.bcd), 32'h1000);
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_first",  first,  WIDTH);
        check("b2b_second", second, 2*WIDTH + 1);
        check("b2b_dones",  dones,  2);

        // Reset in the middle of a conversion.
        bus.bin   = WIDTH'(777);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_bcd",  32'(bus.bcd),  0);
        tick();
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("mid_rst_nodone", dones, 0);
        check("mid_rst_bcd_hold", 32'(bus.bcd), 0);
        run_conv(42, 1'b0, lat, bc);
        check("post_rst_lat", lat, WIDTH);
        check("post_rst_bcd", 32'(bus.bcd), 32'h0042);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
